// File: rtl/ok_bus_pkg.sv
// ok_bus_pkg: shared okHost ok1/ok2 bus layout, reused by every host endpoint.
package ok_bus_pkg;
  localparam int OK1_W         = 31;
  localparam int OK2_W         = 17;
  localparam int OK1_DATA_LSB  = 0;
  localparam int OK1_ADDR_LSB  = 16;
  localparam int OK1_WRITE_BIT = 24;
  localparam int OK1_READ_BIT  = 25;
  localparam int OK1_RESET_BIT = 26;
  localparam int OK2_ACK_BIT   = 16;
  typedef logic [7:0] ok_addr_t;
  function automatic ok_addr_t ok1_addr(input logic [OK1_W-1:0] ok1);
    return ok1[OK1_ADDR_LSB +: 8];
  endfunction
  function automatic logic [15:0] ok1_data(input logic [OK1_W-1:0] ok1);
    return ok1[OK1_DATA_LSB +: 16];
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock RAM FIFO with a registered first-word-fall-through
// head, level counter and synchronous flush; a push at full without a pop is dropped.
module sync_fifo_fwft #(
  parameter int W     = 16,
  parameter int AW    = 9,
  parameter int AFULL = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          ready_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [AW:0]   level_o,
  output logic          afull_o,
  output logic          drop_o
);
  localparam logic [AW:0] DEPTH   = (AW+1)'(1 << AW);
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL);
  logic [W-1:0]  mem [1 << AW];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, afull_q, pop, wr;
  assign pop    = valid_q && ready_i;
  assign wr     = push_i && (level_q < DEPTH || pop);
  assign drop_o = push_i && !wr;
  // The next head bypasses the RAM when it is the word being written this cycle.
  always_comb begin
    rptr_d  = flush_i ? '0 : rptr_q + AW'(pop);
    wptr_d  = flush_i ? '0 : wptr_q + AW'(wr);
    level_d = flush_i ? '0 : level_q + (AW+1)'(wr) - (AW+1)'(pop);
    head_d  = flush_i ? '0 : level_d == '0 ? head_q :
              (wr && rptr_d == wptr_q) ? din_i : mem[rptr_d];
  end
  always_ff @(posedge clk) begin
    if (wr && !flush_i) mem[wptr_q] <= din_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      head_q  <= head_d;
      valid_q <= level_d != '0;
      afull_q <= level_d >= AFULL_L;
    end
  end
  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign afull_o = afull_q;
endmodule

// File: rtl/ok_pipe_in_fifo.sv
// ok_pipe_in_fifo: okHost pipe-in endpoint buffering host writes into a FWFT stream.
// Define OK_PIPE_STAT_EN to enable the fill-level/overflow status readback on ok2.
module ok_pipe_in_fifo
  import ok_bus_pkg::*;
#(
  parameter ok_addr_t EP_ADDR      = 8'h80,
  parameter ok_addr_t STAT_ADDR    = 8'h20,
  parameter int       DEPTH_LOG2   = 9,
  parameter int       AFULL_THRESH = 480
) (
  input  logic                  ti_clk,
  input  logic                  rst_n,
  input  logic [OK1_W-1:0]      ok1,
  output logic [OK2_W-1:0]      ok2,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow
);
  logic flush, push, drop, overflow_q, overflow_d;
  assign flush = ok1[OK1_RESET_BIT];
  assign push  = ok1[OK1_WRITE_BIT] && ok1_addr(ok1) == EP_ADDR;
  sync_fifo_fwft #(
    .W     (16),
    .AW    (DEPTH_LOG2),
    .AFULL (AFULL_THRESH)
  ) u_fifo (
    .clk     (ti_clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (ok1_data(ok1)),
    .ready_i (dout_ready),
    .dout_o  (dout),
    .valid_o (dout_valid),
    .level_o (level),
    .afull_o (almost_full),
    .drop_o  (drop)
  );
  assign overflow_d = flush ? 1'b0 : overflow_q | drop;
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
`ifdef OK_PIPE_STAT_EN
  logic [OK2_W-1:0] ok2_q, ok2_d;
  logic             unused_ok1;
  // Status reply is a one-cycle pulse; a soft reset only affects it from the next cycle.
  assign ok2_d = (ok1[OK1_READ_BIT] && ok1_addr(ok1) == STAT_ADDR) ?
                 {1'b1, overflow_q, almost_full, 4'b0, level[9:0]} : '0;
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) ok2_q <= '0;
    else        ok2_q <= ok2_d;
  end
  assign ok2        = ok2_q;
  assign unused_ok1 = ^ok1[OK1_W-1:OK1_RESET_BIT+1];
`else
  logic unused_stat;
  assign ok2         = '0;
  assign unused_stat = ^{ok1[OK1_W-1:OK1_RESET_BIT+1], ok1[OK1_READ_BIT], STAT_ADDR};
`endif
endmodule
